riscv_fetch_unit: RTL and testbench

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_fetch_unit.sv | 125 ++++++++++++
 tb/tb_riscv_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: issues word reads to instruction memory and presents one
// registered instruction per cycle to decode, squashing wrong-path fetches on redirect.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        pend_q, pend_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    always_comb begin
        imem_req = 1'b0;
        if (!rst) begin
            if (state_q == DRAIN) begin
                imem_req = 1'b1;
            end else begin
                imem_req = !redirect_valid && (!inst_valid_q || inst_ready);
            end
        end
        imem_addr = (state_q == DRAIN) ? align_word(req_addr_q) : align_word(pc_q);
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        pend_d       = 1'b0;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        misalign_d   = redirect_valid && (|redirect_pc[1:0]);

        if (state_q == FETCH) begin
            if (redirect_valid) begin
                pc_d         = align_word(redirect_pc);
                inst_valid_d = 1'b0;
                inst_d       = NOP_INST;
                // A request left unanswered last cycle may still complete; swallow it first.
                if (pend_q) begin
                    state_d = DRAIN;
                end
            end else if (imem_req && imem_ack) begin
                inst_d       = imem_rdata;
                inst_pc_d    = pc_q;
                inst_valid_d = 1'b1;
                pc_d         = pc_q + 32'd4;
            end else begin
                if (imem_req) begin
                    pend_d     = 1'b1;
                    req_addr_d = pc_q;
                end
                if (inst_valid_q && inst_ready) begin
                    inst_valid_d = 1'b0;
                    inst_d       = NOP_INST;
                end
            end
        end else begin
            if (redirect_valid) begin
                pc_d         = align_word(redirect_pc);
                inst_valid_d = 1'b0;
                inst_d       = NOP_INST;
            end
            // The acked word belongs to a squashed path and is never presented.
            if (imem_ack) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'h0000_0000;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            misalign_q   <= misalign_d;
        end
        req_addr_q <= req_addr_d;
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: expected instructions are queued as acks are
// driven and compared as each new instruction appears on the decode interface.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        req_seen;
    logic [31:0] addr_seen;

    riscv_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, capture the request, clock, then score any new instruction.
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
        logic pre_valid;
        exp_t e;
        imem_ack = ack; imem_rdata = rd; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
        #1;
        req_seen  = imem_req;
        addr_seen = imem_addr;
        pre_valid = inst_valid;
        @(posedge clk); #1;
        if (inst_valid && (!pre_valid || rdy)) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_spurious: inst_valid with inst=%h pc=%h, required no instruction", inst, inst_pc);
            end else begin
                e = sb_q.pop_front();
                if (inst !== e.word || inst_pc !== e.pc) begin
                    miscompares++;
                    $display("FAIL sb_inst: got inst=%h pc=%h, required inst=%h pc=%h", inst, inst_pc, e.word, e.pc);
                end
            end
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] p);
        exp_t e;
        e.word = w; e.pc = p;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (req_seen !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b required 0", req_seen); end
        vectors++;
        if ({inst_valid, misalign} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got valid=%b misalign=%b required 0 0", inst_valid, misalign); end
        vectors++;
        if (inst !== NOP_INST || inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h/%h required %h/0", inst, inst_pc, NOP_INST); end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        push(32'h0020_0093, 32'h0);
        cyc(1'b1, 32'h0020_0093, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (req_seen !== 1'b1 || addr_seen !== RESET_PC) begin miscompares++; $display("FAIL first_req: got req=%b addr=%h required 1 %h", req_seen, addr_seen, RESET_PC); end
        vectors++;
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid: got %b required 1", inst_valid); end
        for (int i = 1; i < 3; i++) begin
            push(32'h0020_0093, 32'(i * 4));
            cyc(1'b1, 32'h0020_0093, 1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_stall();
        push(32'h0200_006F, 32'd12);
        cyc(1'b1, 32'h0200_006F, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (req_seen !== 1'b0) begin miscompares++; $display("FAIL stall_req: cycle %0d got %b required 0", i, req_seen); end
            vectors++;
            if (inst !== 32'h0200_006F || inst_pc !== 32'd12 || inst_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold: got %h/%h/%b required 0200006f/0000000c/1", inst, inst_pc, inst_valid);
            end
        end
        push(32'h0040_0113, 32'd16);
        cyc(1'b1, 32'h0040_0113, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addr_seen !== 32'd16) begin miscompares++; $display("FAIL stall_resume: got addr=%h required 00000010", addr_seen); end
    endtask

    task automatic test_ack_wait();
        cyc(1'b0, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (req_seen !== 1'b1 || addr_seen !== 32'd20) begin miscompares++; $display("FAIL wait_req: got %b/%h required 1/00000014", req_seen, addr_seen); end
        vectors++;
        if (inst_valid !== 1'b0 || inst !== NOP_INST) begin miscompares++; $display("FAIL consume_nop: got %b/%h required 0/%h", inst_valid, inst, NOP_INST); end
        cyc(1'b0, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addr_seen !== 32'd20) begin miscompares++; $display("FAIL wait_stable: got %h required 00000014", addr_seen); end
        push(32'h0060_0193, 32'd20);
        cyc(1'b1, 32'h0060_0193, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_drain();
        cyc(1'b0, 32'h3333_3333, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h3333_3333, 1'b1, 32'h0000_0100, 1'b1);
        vectors++;
        if (req_seen !== 1'b0) begin miscompares++; $display("FAIL redir_req: got %b required 0", req_seen); end
        cyc(1'b0, 32'h3333_3333, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (req_seen !== 1'b1 || addr_seen !== 32'd24) begin miscompares++; $display("FAIL drain_hold: got %b/%h required 1/00000018", req_seen, addr_seen); end
        cyc(1'b1, 32'h4444_4444, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addr_seen !== 32'd24 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL drain_ack: got addr=%h valid=%b required 00000018/0", addr_seen, inst_valid); end
        push(32'h0080_0213, 32'h100);
        cyc(1'b1, 32'h0080_0213, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addr_seen !== 32'h100) begin miscompares++; $display("FAIL drain_target: got %h required 00000100", addr_seen); end
    endtask

    task automatic test_redirect_ack();
        cyc(1'b1, 32'h5555_5555, 1'b1, 32'h0000_0042, 1'b1);
        vectors++;
        if (misalign !== 1'b1 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL redir_ack: got misalign=%b valid=%b required 1/0", misalign, inst_valid); end
        push(32'h00A0_0293, 32'h40);
        cyc(1'b1, 32'h00A0_0293, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addr_seen !== 32'h40) begin miscompares++; $display("FAIL redir_target: got %h required 00000040", addr_seen); end
        vectors++;
        if (misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_pulse: got %b required 0", misalign); end
    endtask

    task automatic test_wrap();
        cyc(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        vectors++;
        if (misalign !== 1'b0) begin miscompares++; $display("FAIL aligned_redir: got misalign=%b required 0", misalign); end
        push(32'h00C0_0313, 32'hFFFF_FFFC);
        cyc(1'b1, 32'h00C0_0313, 1'b0, 32'h0, 1'b1);
        push(32'h00E0_0393, 32'h0);
        cyc(1'b1, 32'h00E0_0393, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addr_seen !== 32'h0) begin miscompares++; $display("FAIL pc_wrap: got %h required 00000000", addr_seen); end
    endtask

    task automatic test_reset_drain();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 32'h6666_6666, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (req_seen !== 1'b0) begin miscompares++; $display("FAIL rst_drain_req: got %b required 0", req_seen); end
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_drain_valid: got %b required 0", inst_valid); end
        rst = 1'b0;
        push(32'h0100_0413, RESET_PC);
        cyc(1'b1, 32'h0100_0413, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (req_seen !== 1'b1 || addr_seen !== RESET_PC) begin miscompares++; $display("FAIL rst_restart: got %b/%h required 1/%h", req_seen, addr_seen, RESET_PC); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_ack_wait();
        test_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_drain();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (sb_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover: %0d expected instructions never appeared, required 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
